// File: rtl/axis_checker_pkg.sv
// Shared encodings for the Aurora AXI-Stream packet checker: status codes,
// receive FSM states and the width of the runtime payload-length input.
package axis_checker_pkg;

  typedef enum logic [2:0] {
    ST_SUCCESS        = 3'd0,
    ST_BAD_HEADER     = 3'd1,
    ST_BAD_SIZE       = 3'd2,
    ST_BAD_INDEX      = 3'd3,
    ST_ABORTED        = 3'd4,
    ST_BAD_LENGTH_CFG = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  // Width needed to express 0..max_words inclusive.
  function automatic int len_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear restarts at zero but still counts an
// increment arriving in the same cycle.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)                      count_d = WIDTH'(inc);
    else if (inc && count_q != '1)  count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/axis_packet_checker_multi.sv
// AXI-Stream packet receiver for the Aurora link: validates header, checks
// payload length, delivers good payloads and keeps per-cycle statistics.
module axis_packet_checker_multi
  import axis_checker_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAGIC_WIDTH     = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH     = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int NUM_INDICES     = 32,
  parameter int MAX_DATA_WORDS  = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                                   auroraClk,
  input  logic                                   auroraReset,
  input  logic                                   rxEnable,
  input  logic                                   newCycleStrobe,
  input  logic [len_width(MAX_DATA_WORDS)-1:0]   expectedDataWords,
  input  logic [MAGIC_WIDTH-1:0]                 expectedHeaderMagic,
  input  logic                                   TVALID,
  output logic                                   TREADY,
  input  logic                                   TLAST,
  input  logic [DATA_WIDTH-1:0]                  TDATA,
  output logic                                   statusStrobe,
  output logic [2:0]                             statusCode,
  output logic                                   packetStrobe,
  output logic [INDEX_WIDTH-1:0]                 packetIndex,
  output logic [DATA_WIDTH*MAX_DATA_WORDS-1:0]   packetData,
  output logic [COUNT_WIDTH-1:0]                 goodCount,
  output logic [COUNT_WIDTH-1:0]                 errorCount
);

  localparam int LEN_W = len_width(MAX_DATA_WORDS);

  if (INDEX_START_BIT + INDEX_WIDTH > MAGIC_START_BIT) begin : g_chk_overlap
    $error("index field must lie entirely below the magic field");
  end
  if (MAGIC_START_BIT + MAGIC_WIDTH > DATA_WIDTH) begin : g_chk_magic
    $error("magic field exceeds TDATA width");
  end
  if (MAX_DATA_WORDS < 1) begin : g_chk_depth
    $error("MAX_DATA_WORDS must be at least 1");
  end

  state_e                                   state_q, state_d;
  status_e                                  code_q, code_d;
  logic                                     tready_q;
  logic                                     st_stb_q, st_stb_d, pkt_stb_q, pkt_stb_d;
  logic [LEN_W-1:0]                         cnt_q, cnt_d, len_q, len_d;
  logic [INDEX_WIDTH-1:0]                   idx_q, idx_d, pkt_idx_q, pkt_idx_d;
  logic [MAX_DATA_WORDS-1:0][DATA_WIDTH-1:0] buf_q, buf_d, pkt_data_q, pkt_data_d;
  logic [COUNT_WIDTH-1:0]                   good_int, err_int;
  logic [COUNT_WIDTH-1:0]                   good_snap_q, good_snap_d, err_snap_q, err_snap_d;

  logic                   accept, last_cnt, good_inc, err_inc;
  logic [MAGIC_WIDTH-1:0] hdr_magic;
  logic [INDEX_WIDTH-1:0] hdr_idx;

  assign accept    = TVALID && tready_q;
  assign hdr_magic = TDATA[MAGIC_START_BIT +: MAGIC_WIDTH];
  assign hdr_idx   = TDATA[INDEX_START_BIT +: INDEX_WIDTH];
  assign last_cnt  = (cnt_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    st_stb_d    = 1'b0;
    code_d      = code_q;
    pkt_stb_d   = 1'b0;
    pkt_idx_d   = pkt_idx_q;
    pkt_data_d  = pkt_data_q;
    good_snap_d = good_snap_q;
    err_snap_d  = err_snap_q;

    // A cycle boundary overrides any beat presented in the same cycle.
    if (newCycleStrobe) begin
      good_snap_d = good_int;
      err_snap_d  = err_int;
      if (state_q != S_HEADER) begin
        st_stb_d = 1'b1;
        code_d   = ST_ABORTED;
      end
      state_d = S_HEADER;
      buf_d   = '0;
    end else if (accept) begin
      case (state_q)
        S_HEADER: begin
          st_stb_d = 1'b1;
          if (hdr_magic != expectedHeaderMagic)
            code_d = ST_BAD_HEADER;
          else if (int'(hdr_idx) >= NUM_INDICES)
            code_d = ST_BAD_INDEX;
          else if (expectedDataWords == '0 || int'(expectedDataWords) > MAX_DATA_WORDS)
            code_d = ST_BAD_LENGTH_CFG;
          else if (TLAST)
            code_d = ST_BAD_SIZE;
          else begin
            st_stb_d = 1'b0;
            idx_d    = hdr_idx;
            len_d    = expectedDataWords;
            cnt_d    = '0;
            buf_d    = '0;
            state_d  = S_DATA;
          end
          if (st_stb_d && !TLAST) state_d = S_DRAIN;
        end
        S_DATA: begin
          for (int w = 0; w < MAX_DATA_WORDS; w++)
            if (cnt_q == LEN_W'(w)) buf_d[w] = TDATA;
          if (TLAST) begin
            st_stb_d = 1'b1;
            state_d  = S_HEADER;
            if (last_cnt) begin
              code_d     = ST_SUCCESS;
              pkt_stb_d  = 1'b1;
              pkt_idx_d  = idx_q;
              pkt_data_d = buf_d;
            end else begin
              code_d = ST_BAD_SIZE;
            end
          end else if (last_cnt) begin
            st_stb_d = 1'b1;
            code_d   = ST_BAD_SIZE;
            state_d  = S_DRAIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        S_DRAIN: if (TLAST) state_d = S_HEADER;
        default: state_d = S_HEADER;
      endcase
    end
  end

  assign good_inc = st_stb_d && (code_d == ST_SUCCESS);
  assign err_inc  = st_stb_d && (code_d != ST_SUCCESS);

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_good_cnt (
    .clk(auroraClk), .rst(auroraReset), .inc(good_inc), .clear(newCycleStrobe), .count(good_int)
  );
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_cnt (
    .clk(auroraClk), .rst(auroraReset), .inc(err_inc), .clear(newCycleStrobe), .count(err_int)
  );

  always_ff @(posedge auroraClk) begin
    if (auroraReset) begin
      state_q     <= S_HEADER;
      code_q      <= ST_SUCCESS;
      tready_q    <= 1'b0;
      st_stb_q    <= 1'b0;
      pkt_stb_q   <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      pkt_idx_q   <= '0;
      pkt_data_q  <= '0;
      good_snap_q <= '0;
      err_snap_q  <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      tready_q    <= rxEnable;
      st_stb_q    <= st_stb_d;
      pkt_stb_q   <= pkt_stb_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      pkt_idx_q   <= pkt_idx_d;
      pkt_data_q  <= pkt_data_d;
      good_snap_q <= good_snap_d;
      err_snap_q  <= err_snap_d;
    end
  end

  assign TREADY       = tready_q;
  assign statusStrobe = st_stb_q;
  assign statusCode   = code_q;
  assign packetStrobe = pkt_stb_q;
  assign packetIndex  = pkt_idx_q;
  assign packetData   = pkt_data_q;
  assign goodCount    = good_snap_q;
  assign errorCount   = err_snap_q;

endmodule

// File: tb/tb_axis_packet_checker_multi.sv
// Table-driven bench for axis_packet_checker_multi with a status scoreboard.
module tb_axis_packet_checker_multi;

  localparam int DW   = 32;
  localparam int MW   = 16;
  localparam int IW   = 6;
  localparam int MAXW = 4;
  localparam int CW   = 2;
  localparam int LW   = $clog2(MAXW + 1);
  localparam int PW   = DW * MAXW;

  logic          clk = 1'b0, rst = 1'b1, rx_en = 1'b0, ncs = 1'b0;
  logic [LW-1:0] exp_words = '0;
  logic [MW-1:0] exp_magic = 16'hA5A5;
  logic          tvalid = 1'b0, tlast = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tready, status_stb, pkt_stb;
  logic [2:0]    status_code;
  logic [IW-1:0] pkt_idx;
  logic [PW-1:0] pkt_data;
  logic [CW-1:0] good_cnt, err_cnt;

  axis_packet_checker_multi #(
    .DATA_WIDTH(DW), .MAGIC_WIDTH(MW), .MAGIC_START_BIT(16), .INDEX_WIDTH(IW),
    .INDEX_START_BIT(10), .NUM_INDICES(32), .MAX_DATA_WORDS(MAXW), .COUNT_WIDTH(CW)
  ) dut (
    .auroraClk(clk), .auroraReset(rst), .rxEnable(rx_en), .newCycleStrobe(ncs),
    .expectedDataWords(exp_words), .expectedHeaderMagic(exp_magic),
    .TVALID(tvalid), .TREADY(tready), .TLAST(tlast), .TDATA(tdata),
    .statusStrobe(status_stb), .statusCode(status_code), .packetStrobe(pkt_stb),
    .packetIndex(pkt_idx), .packetData(pkt_data), .goodCount(good_cnt), .errorCount(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    code;
    logic [IW-1:0] idx;
    logic [PW-1:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] magic;
    int          idx;
    int          len;
    int          nb;
    logic [2:0]  code;
  } vec_t;

  exp_t          sb[$];
  exp_t          mon_e;
  vec_t          tbl[12];
  int            checks = 0, failures = 0;
  bit            rand_mode = 1'b0;
  logic [PW-1:0] last_data = '0;
  logic [IW-1:0] last_idx = '0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every status strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (status_stb) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_status: got code %0d expected no strobe", status_code);
        end else begin
          mon_e = sb.pop_front();
          chk("status_code", PW'(status_code), PW'(mon_e.code));
          chk("packet_strobe", PW'(pkt_stb), PW'(mon_e.code == 3'd0));
          if (mon_e.code == 3'd0) begin
            chk("packet_index", PW'(pkt_idx), PW'(mon_e.idx));
            chk("packet_data", pkt_data, mon_e.data);
          end
        end
      end else if (pkt_stb) begin
        checks++; failures++;
        $display("FAIL stray_packet_strobe: got 1 expected 0");
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int   n  = 0;
    logic hs = 1'b0;
    if (rand_mode)
      repeat ($urandom_range(0, 2)) begin
        rx_en = ($urandom_range(0, 3) != 0);
        cycles(1);
      end
    tvalid = 1'b1; tdata = d; tlast = l;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = tready;
      cycles(1);
      n++;
      if (rand_mode) rx_en = ($urandom_range(0, 3) != 0);
    end
    tvalid = 1'b0; tlast = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL beat_timeout: got no handshake expected one within 200 cycles");
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] magic, input int idx);
    logic [DW-1:0] h;
    h = '0;
    h[31:16] = magic;
    h[15:10] = IW'(idx);
    return h;
  endfunction

  task automatic send_pkt(input logic [15:0] magic, input int idx, input int len,
                          input int nb, input logic [2:0] code, input logic [DW-1:0] base);
    exp_t e;
    e.code = code;
    e.idx  = IW'(idx);
    e.data = '0;
    for (int k = 0; k < nb && k < MAXW; k++) e.data[k*DW +: DW] = base + DW'((k + 1) * 'h11);
    if (code == 3'd0) begin
      last_data = e.data;
      last_idx  = e.idx;
    end
    sb.push_back(e);
    exp_words = LW'(len);
    send_beat(mk_hdr(magic, idx), nb == 0);
    for (int k = 0; k < nb; k++) send_beat(base + DW'((k + 1) * 'h11), k == nb - 1);
  endtask

  task automatic pulse_ncs();
    ncs = 1'b1;
    cycles(1);
    ncs = 1'b0;
  endtask

  initial begin
    exp_t ab;
    int   n;

    tbl[0]  = '{16'hA5A5,  3, 2, 2, 3'd0};  // good, data 0x..22_00000011
    tbl[1]  = '{16'h1234,  1, 2, 2, 3'd1};  // wrong magic, drained
    tbl[2]  = '{16'hA5A5,  5, 2, 2, 3'd0};
    tbl[3]  = '{16'hA5A5, 40, 2, 2, 3'd3};  // index out of range
    tbl[4]  = '{16'hA5A5,  2, 3, 2, 3'd2};  // TLAST early
    tbl[5]  = '{16'hA5A5,  2, 2, 4, 3'd2};  // too long, then drain
    tbl[6]  = '{16'hA5A5,  2, 0, 1, 3'd5};
    tbl[7]  = '{16'hA5A5,  2, 5, 1, 3'd5};
    tbl[8]  = '{16'hA5A5, 31, 4, 4, 3'd0};  // max index, max length
    tbl[9]  = '{16'hA5A5,  2, 2, 0, 3'd2};  // header carries TLAST
    tbl[10] = '{16'hA5A5,  0, 1, 1, 3'd0};
    tbl[11] = '{16'h0BAD,  2, 2, 0, 3'd1};  // bad header ending on header

    rx_en = 1'b1;
    cycles(3);
    chk("reset_tready", PW'(tready), '0);
    chk("reset_status_strobe", PW'(status_stb), '0);
    chk("reset_status_code", PW'(status_code), '0);
    chk("reset_packet_index", PW'(pkt_idx), '0);
    chk("reset_packet_data", pkt_data, '0);
    chk("reset_counts", PW'({good_cnt, err_cnt}), '0);
    rst = 1'b0;
    cycles(1);
    chk("tready_after_reset", PW'(tready), PW'(1));

    for (int i = 0; i < 12; i++) begin
      send_pkt(tbl[i].magic, tbl[i].idx, tbl[i].len, tbl[i].nb, tbl[i].code,
               (i == 0) ? '0 : DW'(i << 20));
      cycles(2);
    end
    chk("data_held_after_errors", pkt_data, last_data);
    chk("index_held_after_errors", PW'(pkt_idx), PW'(last_idx));
    chk("status_code_held", PW'(status_code), PW'(3'd1));

    pulse_ncs();
    chk("sat_good_count", PW'(good_cnt), PW'(3));
    chk("sat_error_count", PW'(err_cnt), PW'(3));

    for (int i = 0; i < 3; i++) begin
      send_pkt(16'hA5A5, 7 + i, 2, 2, 3'd0, DW'((i + 1) << 24));
      cycles(1);
    end
    send_pkt(16'hBEEF, 1, 2, 2, 3'd1, '0);
    cycles(2);

    // Abort mid-payload; the TLAST beat in the strobe cycle must be dropped.
    exp_words = 2;
    send_beat(mk_hdr(16'hA5A5, 10), 1'b0);
    send_beat(32'h55, 1'b0);
    ab.code = 3'd4; ab.idx = '0; ab.data = '0;
    sb.push_back(ab);
    tvalid = 1'b1; tdata = 32'h66; tlast = 1'b1; ncs = 1'b1;
    cycles(1);
    tvalid = 1'b0; tlast = 1'b0; ncs = 1'b0;
    chk("cycle_good_count", PW'(good_cnt), PW'(3));
    chk("cycle_error_count", PW'(err_cnt), PW'(1));
    cycles(2);
    pulse_ncs();
    chk("aborted_in_new_cycle_good", PW'(good_cnt), PW'(0));
    chk("aborted_in_new_cycle_err", PW'(err_cnt), PW'(1));

    rand_mode = 1'b1;
    for (int i = 0; i < 5; i++) send_pkt(16'hA5A5, 20 + i, 1 + (i % 4), 1 + (i % 4), 3'd0, DW'((i + 9) << 24));
    rand_mode = 1'b0;
    rx_en = 1'b1;
    cycles(3);
    pulse_ncs();
    chk("rand_good_saturated", PW'(good_cnt), PW'(3));
    chk("rand_error_count", PW'(err_cnt), PW'(0));

    // Reset in the middle of a packet: no status, outputs back to zero.
    exp_words = 2;
    send_beat(mk_hdr(16'hA5A5, 4), 1'b0);
    send_beat(32'h77, 1'b0);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);
    chk("midreset_packet_data", pkt_data, '0);
    chk("midreset_status_code", PW'(status_code), '0);
    chk("midreset_counts", PW'({good_cnt, err_cnt}), '0);
    send_pkt(16'hA5A5, 6, 3, 3, 3'd0, 32'h0C00_0000);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycles(1);
      n++;
    end
    chk("scoreboard_empty", PW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_checker_multi.md
Name: axis_packet_checker_multi

Overview:
Synthesisable, parametrised AXI-Stream packet receiver/checker for the Aurora link. Validates header magic and index range and checks the runtime-programmable payload length. Delivers complete payloads with a one-cycle strobe. Keeps saturating per-cycle good/error counters that are snapshotted on each newCycleStrobe for readout by the local-bus status registers.

Parameters:
DATA_WIDTH, 32, TDATA width in bits (32 or 64)
MAGIC_WIDTH, 16, header magic width
MAGIC_START_BIT, 16, LSB of magic in header beat
INDEX_WIDTH, 5, header index width
INDEX_START_BIT, 10, LSB of index in header beat; index field must lie below the magic field
NUM_INDICES, 32, valid indices are 0..NUM_INDICES-1
MAX_DATA_WORDS, 4, payload buffer depth in beats; must be >=1
COUNT_WIDTH, 16, statistics counter width

Ports:
auroraClk  in  1  link clock
auroraReset  in  1  reset, synchronous active-high
rxEnable  in  1  gates TREADY
newCycleStrobe  in  1  start of a new acquisition cycle
expectedDataWords  in  $clog2(MAX_DATA_WORDS+1)  payload beats per packet
expectedHeaderMagic  in  MAGIC_WIDTH  required magic
TVALID  in  1  AXIS valid
TREADY  out  1  AXIS ready
TLAST  in  1  AXIS last
TDATA  in  DATA_WIDTH  AXIS data
statusStrobe  out  1  one-cycle pulse, statusCode valid
statusCode  out  3  result code
packetStrobe  out  1  one-cycle pulse on good packet
packetIndex  out  INDEX_WIDTH  index of delivered packet
packetData  out  DATA_WIDTH*MAX_DATA_WORDS  payload, word 0 in LSBs
goodCount  out  COUNT_WIDTH  good packets in previous cycle
errorCount  out  COUNT_WIDTH  errored packets in previous cycle

Behaviour:
- Reset: state=S_HEADER; TREADY, strobes, statusCode, packetIndex, packetData, counters and snapshots = 0.
- TREADY registered: equals rxEnable delayed one cycle; 0 while auroraReset is asserted. A beat is accepted when TVALID&&TREADY.
- Status codes: 0 SUCCESS, 1 BAD_HEADER (magic mismatch), 2 BAD_SIZE, 3 BAD_INDEX, 4 ABORTED, 5 BAD_LENGTH_CFG.
- S_HEADER, beat accepted:
  - If magic mismatches -> BAD_HEADER.
  - Else if index >= NUM_INDICES -> BAD_INDEX.
  - Else if expectedDataWords is 0 or >MAX_DATA_WORDS -> BAD_LENGTH_CFG.
  - Else if TLAST -> BAD_SIZE.
  - Otherwise latch index and length, clear the beat counter, go to S_DATA.
  - On any error: go to S_DRAIN if TLAST=0, else stay in S_HEADER.
- S_DATA: store beat at buffer[count].
  - TLAST with count==len-1 -> SUCCESS and packetStrobe; go to S_HEADER.
  - TLAST with count<len-1 -> BAD_SIZE; go to S_HEADER.
  - count==len-1 without TLAST -> BAD_SIZE; go to S_DRAIN.
  - Otherwise count+1.
- S_DRAIN: discard beats until TLAST, then go to S_HEADER. No extra status.
- Exactly one statusStrobe per packet.
- Strobes assert the cycle after the deciding beat handshake and last one cycle. statusCode holds its value until the next strobe.
- On SUCCESS, packetData and packetIndex update in the same cycle as packetStrobe. Buffer words >= len are zero. Outputs hold until the next SUCCESS. The working buffer is separate from the output register, so a failed packet never disturbs the delivered data.
- Counters: SUCCESS increments goodCount_int; every other code increments errorCount_int. Both saturate at all-ones.
- newCycleStrobe (highest priority):
  - Copy the internal counters to goodCount/errorCount.
  - Reset the internal counters to 0. An event in the same cycle counts into the new cycle.
  - If state != S_HEADER, emit ABORTED (counted in the new cycle).
  - Force state to S_HEADER and clear the working buffer.
  - A beat accepted in the same cycle is dropped.
- auroraReset mid-packet: immediate return to reset values. No ABORTED status.

Decomposition:
- Shared package axis_checker_pkg: status code constants, state encodings, width helper for expectedDataWords.
- Elaboration-time checks on index/magic overlap and MAX_DATA_WORDS>=1.
- Sub-module sat_counter (width parameter; inputs inc and clear; output count) instantiated twice.

Test Plan:
- Magic 0xA5A5, index 3, len 2, beats {hdr, 0x11, 0x22+TLAST} -> SUCCESS; packetIndex=3; packetData[63:0]=0x0000002200000011.
- Header magic 0x1234 followed by 2 beats, last with TLAST -> single BAD_HEADER; next good packet delivered normally.
- Index 40 with NUM_INDICES=32 -> BAD_INDEX; 3 beats short (TLAST early, len=3) -> BAD_SIZE; 4 beats with len=2 -> BAD_SIZE, then drain.
- expectedDataWords=0 -> BAD_LENGTH_CFG; =5 with MAX=4 -> BAD_LENGTH_CFG.
- newCycleStrobe mid-payload after 3 good and 1 bad packets -> goodCount=3, errorCount=1, ABORTED strobe; new-cycle errorCount_int=1.
- Random TVALID with rxEnable toggling, COUNT_WIDTH=2, 5 good packets -> goodCount saturates at 3; no beat lost or duplicated.
